// File: rtl/life_controller.sv
// Top-level sequencer for the 16x16 Game of Life board: button debounce, setup-mode
// row editing, run-mode generation pacing with a request/done engine handshake.
module life_controller #(
  parameter int TICK_CYCLES     = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnC,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic [15:0] Sw,
  input  logic        step_done,
  output logic [3:0]  row_index,
  output logic        row_wr_en,
  output logic [15:0] row_wr_data,
  output logic        clear_board,
  output logic        step_req,
  output logic        running,
  output logic [15:0] gen_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [1:0] SETUP    = 2'd0;
  localparam logic [1:0] RUN_WAIT = 2'd1;
  localparam logic [1:0] RUN_STEP = 2'd2;

  localparam int B_D = 0;
  localparam int B_U = 1;
  localparam int B_C = 2;
  localparam int B_R = 3;
  localparam int B_L = 4;

  logic [4:0]    btn_raw;
  logic [4:0]    btn_s1, btn_s2;
  logic [4:0]    level, level_d;
  logic [4:0]    press;
  logic [CW-1:0] db_cnt [5];
  logic [15:0]   sw_s1, sw_s2;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          pause_pending;

  assign btn_raw = {BtnL, BtnR, BtnC, BtnU, BtnD};
  assign press   = level & ~level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      level_d <= '0;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      sw_s1   <= Sw;
      sw_s2   <= sw_s1;
      level_d <= level;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  for (genvar b = 0; b < 5; b++) begin : g_debounce
    always_ff @(posedge clk) begin
      if (reset) begin
        level[b]  <= 1'b0;
        db_cnt[b] <= '0;
      end else if (btn_s2[b] == level[b]) begin
        db_cnt[b] <= '0;
      end else if (db_cnt[b] == DB_LAST) begin
        level[b]  <= btn_s2[b];
        db_cnt[b] <= '0;
      end else begin
        db_cnt[b] <= db_cnt[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SETUP;
      row_index     <= '0;
      row_wr_en     <= 1'b0;
      row_wr_data   <= '0;
      clear_board   <= 1'b0;
      step_req      <= 1'b0;
      running       <= 1'b0;
      gen_count     <= '0;
      timer         <= '0;
      pause_pending <= 1'b0;
    end else begin
      row_wr_en   <= 1'b0;
      clear_board <= 1'b0;
      case (state)
        SETUP: begin
          if (press[B_L]) begin
            clear_board <= 1'b1;
            row_index   <= '0;
            gen_count   <= '0;
          end else if (press[B_R]) begin
            state   <= RUN_WAIT;
            timer   <= '0;
            running <= 1'b1;
          end else if (press[B_C]) begin
            row_wr_en   <= 1'b1;
            row_wr_data <= sw_s2;
          end else if (press[B_U] && !press[B_D]) begin
            if (row_index != 4'd0) row_index <= row_index - 1'b1;
          end else if (press[B_D] && !press[B_U]) begin
            if (row_index != 4'd15) row_index <= row_index + 1'b1;
          end
        end
        RUN_WAIT: begin
          if (press[B_R]) begin
            state   <= SETUP;
            timer   <= '0;
            running <= 1'b0;
          end else if (timer == TICK_LAST) begin
            timer    <= '0;
            state    <= RUN_STEP;
            step_req <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN_STEP: begin
          // A pause request never aborts the step; it takes effect once the engine is done.
          if (step_done) begin
            step_req      <= 1'b0;
            gen_count     <= gen_count + 1'b1;
            timer         <= '0;
            pause_pending <= 1'b0;
            if (pause_pending || press[B_R]) begin
              state   <= SETUP;
              running <= 1'b0;
            end else begin
              state <= RUN_WAIT;
            end
          end else if (press[B_R]) begin
            pause_pending <= 1'b1;
          end
        end
        default: begin
          state    <= SETUP;
          running  <= 1'b0;
          step_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/life_controller.md
Name: life_controller

Overview:
Top-level sequencer for the 16x16 Game of Life board. It debounces the board buttons and, in SETUP mode, steers the row cursor and issues row-write commands built from the switch word. In RUN mode it paces generation updates with a tick timer and a request/done handshake to the evolution engine. It also owns board clear and the generation counter.

Parameters:
TICK_CYCLES, 50000000, clk cycles between generation steps in RUN (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
BtnU  input  1  raw button: cursor up (row_index-1)
BtnD  input  1  raw button: cursor down (row_index+1)
BtnC  input  1  raw button: write switch word to current row
BtnL  input  1  raw button: clear board
BtnR  input  1  raw button: run/pause toggle
Sw  input  16  raw switch word, Sw[i] is column i
step_done  input  1  engine completed one generation (1-cycle pulse)
row_index  output  4  current setup row cursor
row_wr_en  output  1  1-cycle row write strobe
row_wr_data  output  16  row contents, valid with row_wr_en
clear_board  output  1  1-cycle board clear strobe
step_req  output  1  generation step request, held until step_done
running  output  1  high in RUN_WAIT/RUN_STEP
gen_count  output  16  generations completed since reset/clear

Behaviour:
- Reset (sync, active-high): state=SETUP, row_index=0, row_wr_en=0, row_wr_data=0, clear_board=0, step_req=0, running=0, gen_count=0, tick timer=0, all debouncers debounced level=0, stable counters=0, sync FFs=0.
- Inputs: each button and Sw bit passes through a 2-FF synchronizer.
- Debounce, per button: a counter increments while the synced level differs from the debounced level and clears when they agree. When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
- A debounced 0->1 transition produces a press pulse for exactly one cycle. Release produces no pulse.
- Press latency from the raw edge: 2 (sync) + DEBOUNCE_CYCLES cycles. The action is visible on outputs one cycle later.
- FSM states: SETUP, RUN_WAIT, RUN_STEP.
- SETUP, press handling (one action per cycle, priority L > R > C > U/D):
  - L: clear_board=1 for 1 cycle; row_index=0; gen_count=0.
  - R: go to RUN_WAIT with timer=0.
  - C: row_wr_en=1 for 1 cycle; row_wr_data=synced Sw sampled that cycle; row_index unchanged.
  - U: row_index-1, saturating at 0.
  - D: row_index+1, saturating at 15. No wrap in either direction.
  - U and D pressed in the same cycle: both ignored.
  - Lower-priority presses in the same cycle are dropped, not queued.
- RUN_WAIT:
  - Timer counts up every cycle.
  - At timer==TICK_CYCLES-1: timer=0, go to RUN_STEP, step_req=1 from the next cycle.
  - R press: go to SETUP; timer cleared.
  - L, C, U, D presses are ignored in RUN.
- RUN_STEP:
  - step_req held at 1 until step_done is seen.
  - On step_done: step_req=0 next cycle; gen_count+1, wrapping 0xFFFF->0.
  - Next state is RUN_WAIT (timer=0), or SETUP if an R press occurred during RUN_STEP.
  - An R press during RUN_STEP is latched as pause_pending. The step always completes; there is no abort.
- step_done outside RUN_STEP: ignored, with no gen_count change.
- running = (state != SETUP), registered.
- row_wr_en and clear_board are never asserted in RUN states. row_wr_data holds its last value when row_wr_en=0.
- Reset mid-step: step_req=0 on the cycle after reset is sampled; a later step_done is ignored.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=8.)
1. Reset, then BtnD held high 20 cycles, released, repeated 3 times -> row_index=3. Then 5 BtnU presses -> row_index=0 (saturates, never 15).
2. row_index=5, Sw=16'hA5C3, BtnC press -> exactly one cycle with row_wr_en=1, row_wr_data=16'hA5C3, row_index=5. A BtnC glitch high for 3 cycles -> no row_wr_en.
3. BtnR press, step_done returned 2 cycles after each step_req rise -> running=1; first step_req rises 8 cycles after entering RUN_WAIT. After 3 steps, gen_count=3 and step_req is never high across a step_done.
4. BtnR pressed while step_req=1, step_done delayed 10 cycles -> step_req stays high until step_done, gen_count increments, then state=SETUP, running=0.
5. gen_count=3 in SETUP, BtnL press -> clear_board one-cycle pulse, gen_count=0, row_index=0. BtnL and BtnC pressed simultaneously -> clear only, no row_wr_en.
6. Reset asserted while step_req=1 -> next cycle step_req=0, running=0. A subsequent step_done pulse -> gen_count stays 0.
